image_row_sequencer: RTL and testbench
======================================

IMAGE_ROW_SEQUENCER -- requirements
Module: image_row_sequencer

Interface
REQ-001 Parameter BW, default 32: ROM word / pixel width in bits.
REQ-002 Parameter IM_SIZE, default 32: image edge length; pixels per row and rows per frame.
REQ-003 Parameter SS_W, default 4: sample-select width; the ROM holds 2^SS_W images.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to stream the currently selected image.
REQ-007 next_sample  in  1  one-cycle request to advance the sample select.
REQ-008 rom_data  in  BW  ROM read data, valid exactly one cycle after rom_en.
REQ-009 row_ready  in  1  downstream accepts the presented row.
REQ-010 rom_en  out  1  ROM read strobe.
REQ-011 rom_addr  out  SS_W+10  ROM read address {ss, row[4:0], col[4:0]}.
REQ-012 row_data  out  BW*IM_SIZE  assembled row; word c occupies bits [c*BW +: BW].
REQ-013 row_valid  out  1  row_data holds a complete row.
REQ-014 row_idx  out  5  index of the row currently presented.
REQ-015 frame_done  out  1  one-cycle pulse after the last row is accepted.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 ss  out  SS_W  current sample select.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, PRESENT.
REQ-019 IDLE: start=1 -> FETCH with row=0 and col=0.
REQ-020 FETCH:
- rom_en=1 every cycle.
- rom_addr={ss,row,col}.
- col increments each cycle.
- col=IM_SIZE-1 -> DRAIN.
REQ-021 Each rom_data word returned one cycle after issue is written to row_data word c, where c is the col it was issued with; no shift ordering is used.
REQ-022 DRAIN: one cycle, rom_en=0, captures the last word, then -> PRESENT.
REQ-023 PRESENT:
- row_valid=1 and row_idx=row.
- row_data is held stable until the handshake.
REQ-024 Handshake: the row transfers on a cycle with row_valid=1 and row_ready=1; row_valid drops the next cycle.
REQ-025 After transfer:
- row<IM_SIZE-1: row increments, col=0, -> FETCH.
- Otherwise: -> IDLE with frame_done=1 for one cycle.
REQ-026 Single row buffer: no fetch of the next row begins before the current row transfers.
REQ-027 Latency: start seen at edge k; first rom_en in cycle k+1; row_valid first high in cycle k+IM_SIZE+2.
REQ-028 Zero-stall frame time: IM_SIZE*(IM_SIZE+2) cycles from the first rom_en to frame_done.
REQ-029 start while busy is ignored.
REQ-030 next_sample in IDLE: ss <= ss+1, wrapping from 2^SS_W-1 to 0.
REQ-031 next_sample while busy is ignored; ss is constant for a whole frame.
REQ-032 start and next_sample high together in IDLE: ss advances first, and the frame streams the new ss.
REQ-033 row_ready while row_valid=0 has no effect.
REQ-034 Counter widths are exact: col and row are 5 bits, and no counter overflows past IM_SIZE-1.

Reset
REQ-035 rst=1 immediately forces, regardless of clk:
- state=IDLE, row=0, col=0, ss=0.
- rom_en=0, rom_addr=0, row_valid=0, row_idx=0, frame_done=0, busy=0.
- row_data=0.
REQ-036 Reset mid-frame abandons the frame; after release, no residual rom_en, row_valid or frame_done occurs.
REQ-037 Reset release with start=1 on the first edge is a legal start.

Structure
REQ-038 A shared package holds:
- the state enum;
- constants BW, IM_SIZE, SS_W;
- the ROM address width and field offsets.
The pixel-array loader and downstream FFT/conv stages use the same package.
REQ-039 One sub-module, row_assembler, holds the BW*IM_SIZE register array with an indexed write port (index, data, we) and a clear.
REQ-040 The FSM and counters stay in the top level.

Verification
REQ-041 Reset, ss=0, start pulse, row_ready tied 1:
- rom_addr steps 0..1023;
- 32 row_valid pulses with row_idx 0..31;
- frame_done 32*34=1088 cycles after the first rom_en.
REQ-042 ROM word = address; two next_sample pulses, then start:
- ss=2;
- row 5 presents words 2208..2239, in word order 0..31.
REQ-043 row_ready held 0 for 10 cycles on row 3:
- row_valid and row_data stay stable;
- rom_en stays 0;
- after ready, row 4 fetch starts the next cycle.
REQ-044 start, and next_sample at ss=15, pulsed mid-frame:
- both are ignored, ss stays 15;
- after frame_done, a next_sample pulse gives ss=0.
REQ-045 rst asserted during FETCH of row 7, col 12:
- all outputs are 0 immediately;
- no rom_en until a new start;
- the new frame begins at row 0.
REQ-046 start and next_sample in the same IDLE cycle with ss=6: the frame streams addresses {7,row,col}.

Source files
------------

// File: rtl/image_row_sequencer_pkg.sv
// Shared definitions for the image streaming path: geometry defaults,
// ROM address field layout and the row sequencer state encoding.
package image_row_sequencer_pkg;

  localparam int IRS_BW      = 32;
  localparam int IRS_IM_SIZE = 32;
  localparam int IRS_SS_W    = 4;

  localparam int COL_W   = 5;
  localparam int ROW_W   = 5;
  localparam int COL_OFS = 0;
  localparam int ROW_OFS = COL_OFS + COL_W;
  localparam int SS_OFS  = ROW_OFS + ROW_W;
  localparam int ADDR_W  = IRS_SS_W + SS_OFS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

endpackage

// File: rtl/row_assembler.sv
// Row buffer: BW*N register array with a single indexed word write port
// and a synchronous clear.
module row_assembler
  import image_row_sequencer_pkg::*;
#(
  parameter int BW    = IRS_BW,
  parameter int N     = IRS_IM_SIZE,
  parameter int IDX_W = COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [BW-1:0]     i_data,
  output logic [BW*N-1:0]   o_row
);

  logic [BW*N-1:0] r_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
    end else if (i_clr) begin
      r_row <= '0;
    end else if (i_we) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (i_idx == IDX_W'(c)) r_row[c*BW +: BW] <= i_data;
      end
    end
  end

  assign o_row = r_row;

endmodule

// File: rtl/image_row_sequencer.sv
// Streams one image from ROM row by row: fetch IM_SIZE words into the row
// buffer, present the row, wait for the downstream handshake, repeat.
module image_row_sequencer
  import image_row_sequencer_pkg::*;
#(
  parameter int BW      = IRS_BW,
  parameter int IM_SIZE = IRS_IM_SIZE,
  parameter int SS_W    = IRS_SS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    next_sample,
  input  logic [BW-1:0]           rom_data,
  input  logic                    row_ready,
  output logic                    rom_en,
  output logic [SS_W+SS_OFS-1:0]  rom_addr,
  output logic [BW*IM_SIZE-1:0]   row_data,
  output logic                    row_valid,
  output logic [ROW_W-1:0]        row_idx,
  output logic                    frame_done,
  output logic                    busy,
  output logic [SS_W-1:0]         ss
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IM_SIZE - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IM_SIZE - 1);

  state_e           r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [SS_W-1:0]  r_ss;
  logic             r_cap_vld;
  logic [COL_W-1:0] r_cap_col;
  logic             r_frame_done;

  logic w_fetch;
  logic w_start;
  logic w_xfer;

  assign w_fetch = (r_state == ST_FETCH);
  assign w_start = (r_state == ST_IDLE) && start;
  assign w_xfer  = (r_state == ST_PRESENT) && row_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_ss         <= '0;
      r_cap_vld    <= 1'b0;
      r_cap_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // Remember which column each read was issued for; its data lands next cycle.
      r_cap_vld    <= w_fetch;
      r_cap_col    <= r_col;
      case (r_state)
        ST_IDLE: begin
          if (next_sample) r_ss <= r_ss + SS_W'(1);
          if (start) begin
            r_state <= ST_FETCH;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_FETCH: begin
          if (r_col == LAST_COL) r_state <= ST_DRAIN;
          else                   r_col   <= r_col + COL_W'(1);
        end
        ST_DRAIN: r_state <= ST_PRESENT;
        ST_PRESENT: begin
          if (row_ready) begin
            r_col <= '0;
            if (r_row == LAST_ROW) begin
              r_state      <= ST_IDLE;
              r_row        <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
              r_row   <= r_row + ROW_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  row_assembler #(
    .BW    (BW),
    .N     (IM_SIZE),
    .IDX_W (COL_W)
  ) u_row_assembler (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_we   (r_cap_vld),
    .i_idx  (r_cap_col),
    .i_data (rom_data),
    .o_row  (row_data)
  );

  assign rom_en     = w_fetch;
  assign rom_addr   = w_fetch ? {r_ss, r_row, r_col} : '0;
  assign row_valid  = (r_state == ST_PRESENT);
  assign row_idx    = r_row;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_IDLE);
  assign ss         = r_ss;

  logic w_unused;
  assign w_unused = w_xfer;

endmodule

// File: tb/tb_image_row_sequencer.sv
// Scoreboard bench: stimulus pushes expected ROM addresses, row transfers and
// frame_done pulses (each with its cycle); a negedge monitor pops and compares.
module tb_image_row_sequencer;

  localparam int BW  = 32;
  localparam int IM  = 32;
  localparam int SSW = 4;
  localparam int AW  = SSW + 10;
  localparam int RT  = IM + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                next_sample = 1'b0;
  logic [BW-1:0]       rom_data = '0;
  logic                row_ready = 1'b1;
  logic                rom_en;
  logic [AW-1:0]       rom_addr;
  logic [BW*IM-1:0]    row_data;
  logic                row_valid;
  logic [4:0]          row_idx;
  logic                frame_done;
  logic                busy;
  logic [SSW-1:0]      ss;

  image_row_sequencer #(.BW(BW), .IM_SIZE(IM), .SS_W(SSW)) dut (
    .clk(clk), .rst(rst), .start(start), .next_sample(next_sample),
    .rom_data(rom_data), .row_ready(row_ready), .rom_en(rom_en),
    .rom_addr(rom_addr), .row_data(row_data), .row_valid(row_valid),
    .row_idx(row_idx), .frame_done(frame_done), .busy(busy), .ss(ss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM returns its own address one cycle after the strobe; garbage otherwise.
  always @(posedge clk) rom_data <= rom_en ? BW'(rom_addr) : 32'hDEAD_BEEF;

  typedef struct { logic [AW-1:0] addr; int cyc; } addr_t;
  typedef struct { int idx; int ssv; int cyc; } row_t;

  addr_t q_addr[$];
  row_t  q_row[$];
  int    q_fd[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected traffic of one frame; optional stall on a row, optional cut-off at (stop_r, stop_c).
  task automatic push_frame(input int ssv, input int k, input int stall_row, input int stall_len,
                            input int stop_r, input int stop_c);
    addr_t a;
    row_t  rw;
    bit    cut;
    int    sh;
    cut = (stop_r >= 0);
    for (int r = 0; r < IM; r++) begin
      for (int c = 0; c < IM; c++) begin
        if (cut && (r > stop_r || (r == stop_r && c >= stop_c))) continue;
        sh = (stall_row >= 0 && r > stall_row) ? stall_len : 0;
        a.addr = AW'((ssv << 10) | (r << 5) | c);
        a.cyc  = k + RT*r + c + sh;
        q_addr.push_back(a);
      end
      if (!(cut && r >= stop_r)) begin
        sh = (stall_row >= 0 && r >= stall_row) ? stall_len : 0;
        rw.idx = r; rw.ssv = ssv; rw.cyc = k + RT*r + IM + 1 + sh;
        q_row.push_back(rw);
      end
    end
    if (!cut) q_fd.push_back(k + IM*RT + ((stall_row >= 0) ? stall_len : 0));
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_next();
    next_sample = 1'b1; @(posedge clk); #1; next_sample = 1'b0;
  endtask

  task automatic do_start(input bit with_next, output int k);
    start = 1'b1; next_sample = with_next; k = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; next_sample = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_en"}, 64'(rom_en), 0);
    chk({tag, "_rom_addr"}, 64'(rom_addr), 0);
    chk({tag, "_row_valid"}, 64'(row_valid), 0);
    chk({tag, "_row_idx"}, 64'(row_idx), 0);
    chk({tag, "_frame_done"}, 64'(frame_done), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_ss"}, 64'(ss), 0);
    chk({tag, "_row_data_or"}, 64'(|row_data), 0);
  endtask

  // Monitor
  bit               prev_stall = 1'b0;
  logic [BW*IM-1:0] prev_data;
  logic [4:0]       prev_idx;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rom_en) begin
        n_cmp++;
        if (q_addr.size() == 0) begin
          n_bad++;
          $display("FAIL rom_en_unexpected: got addr %0h at cycle %0d, required no read", rom_addr, cyc);
        end else begin
          addr_t e;
          e = q_addr.pop_front();
          if (rom_addr !== e.addr || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL rom_addr: got %0h at cycle %0d, required %0h at cycle %0d",
                     rom_addr, cyc, e.addr, e.cyc);
          end
        end
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(row_valid), 1);
        chk("stall_idx", 64'(row_idx), 64'(prev_idx));
        chk("stall_data_same", 64'(row_data == prev_data), 1);
      end
      prev_stall = row_valid && !row_ready;
      prev_data  = row_data;
      prev_idx   = row_idx;
      if (row_valid && row_ready) begin
        n_cmp++;
        if (q_row.size() == 0) begin
          n_bad++;
          $display("FAIL row_unexpected: got row %0d at cycle %0d, required none", row_idx, cyc);
        end else begin
          row_t e;
          int   bad_c;
          logic [BW-1:0] w, we_;
          logic [BW-1:0] bad_act, bad_exp;
          e = q_row.pop_front();
          if (row_idx !== 5'(e.idx) || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL row_xfer: got row %0d at cycle %0d, required row %0d at cycle %0d",
                     row_idx, cyc, e.idx, e.cyc);
          end
          bad_c = -1; bad_act = '0; bad_exp = '0;
          for (int c = 0; c < IM; c++) begin
            w   = row_data[c*BW +: BW];
            we_ = BW'(e.ssv*1024 + e.idx*32 + c);
            if (w !== we_ && bad_c < 0) begin bad_c = c; bad_act = w; bad_exp = we_; end
          end
          n_cmp++;
          if (bad_c >= 0) begin
            n_bad++;
            $display("FAIL row_data: row %0d word %0d got %0h required %0h", e.idx, bad_c, bad_act, bad_exp);
          end
        end
      end
      if (frame_done) begin
        n_cmp++;
        if (q_fd.size() == 0) begin
          n_bad++;
          $display("FAIL frame_done_unexpected: got pulse at cycle %0d, required none", cyc);
        end else begin
          int e;
          e = q_fd.pop_front();
          if (cyc != e) begin
            n_bad++;
            $display("FAIL frame_done: got cycle %0d required cycle %0d", cyc, e);
          end
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Release reset with start already high: plain frame, ss=0, ready tied high.
    rst = 1'b0;
    do_start(1'b0, k);
    push_frame(0, k, -1, 0, -1, 0);
    #1 chk("busy_after_start", 64'(busy), 1);
    wait_cyc(k + IM*RT + 2);
    chk("busy_idle", 64'(busy), 0);

    // ss=2, with row 3 stalled for 10 cycles.
    pulse_next();
    pulse_next();
    chk("ss_two", 64'(ss), 2);
    do_start(1'b0, k);
    push_frame(2, k, 3, 10, -1, 0);
    wait_cyc(k + RT*2 + IM + 2);
    row_ready = 1'b0;
    wait_cyc(k + RT*3 + IM + 1 + 10);
    row_ready = 1'b1;
    wait_cyc(k + IM*RT + 10 + 2);

    // start and next_sample together at ss=6 stream ss=7.
    repeat (4) pulse_next();
    chk("ss_six", 64'(ss), 6);
    do_start(1'b1, k);
    push_frame(7, k, -1, 0, -1, 0);
    chk("ss_seven", 64'(ss), 7);
    wait_cyc(k + IM*RT + 2);

    // ss=15: mid-frame start/next_sample ignored; wrap afterwards.
    repeat (8) pulse_next();
    chk("ss_fifteen", 64'(ss), 15);
    do_start(1'b0, k);
    push_frame(15, k, -1, 0, -1, 0);
    wait_cyc(k + 300);
    start = 1'b1; next_sample = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; next_sample = 1'b0;
    chk("ss_held_midframe", 64'(ss), 15);
    wait_cyc(k + IM*RT + 2);
    chk("ss_held_after", 64'(ss), 15);
    pulse_next();
    chk("ss_wrap", 64'(ss), 0);

    // Reset during FETCH of row 7, col 12.
    repeat (3) pulse_next();
    chk("ss_three", 64'(ss), 3);
    do_start(1'b0, k);
    push_frame(3, k, -1, 0, 7, 12);
    wait_cyc(k + RT*7 + 12);
    rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(cyc + 8);
    chk("busy_post_rst", 64'(busy), 0);
    do_start(1'b0, k);
    push_frame(0, k, -1, 0, -1, 0);
    wait_cyc(k + IM*RT + 4);

    chk("addr_queue_empty", 64'(q_addr.size()), 0);
    chk("row_queue_empty", 64'(q_row.size()), 0);
    chk("fd_queue_empty", 64'(q_fd.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
